// File: rtl/cnn_mac_pipe_sat.sv
// cnn_mac_pipe_sat: pipelined signed MAC over ACC_LEN-term windows.
// Each window sum is rounded, shifted and saturated to DOUT_WIDTH.
module cnn_mac_pipe_sat #(
    parameter int DIN0_WIDTH = 14,
    parameter int DIN1_WIDTH = 9,
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 16,
    parameter int SHIFT      = 8,
    parameter int ACC_LEN    = 25,
    parameter int NUM_STAGE  = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic                  acc_clr,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  sat
);
    localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
    localparam int NP = NUM_STAGE - 1;
    localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;
    localparam int RS = SHIFT > 0 ? SHIFT - 1 : 0;
    localparam logic [ACC_WIDTH:0] RND  = SHIFT > 0 ? (ACC_WIDTH+1)'(1) << RS : '0;
    localparam logic [ACC_WIDTH:0] DMAX = {{(ACC_WIDTH+2-DOUT_WIDTH){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH:0] DMIN = ~DMAX;

    logic [DIN0_WIDTH-1:0] r_a;
    logic [DIN1_WIDTH-1:0] r_b;
    logic                  r_iv;
    logic [PW-1:0]         r_p [NP];
    logic [NP-1:0]         r_pv;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [CW-1:0]         r_cnt;

    logic [PW-1:0]         w_prod;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic [ACC_WIDTH:0]    w_rnd;
    logic                  w_last;
    logic                  w_hi;
    logic                  w_lo;

    assign w_prod = PW'($signed(r_a)) * PW'($signed(r_b));
    assign w_sum  = (r_cnt == '0 ? '0 : r_acc) + ACC_WIDTH'($signed(r_p[NP-1]));
    assign w_last = r_cnt == CW'(ACC_LEN - 1);
    // one extra bit keeps the rounding add from overflowing the accumulator range
    assign w_rnd  = ($signed({w_sum[ACC_WIDTH-1], w_sum}) + $signed(RND)) >>> SHIFT;
    assign w_hi   = $signed(w_rnd) > $signed(DMAX);
    assign w_lo   = $signed(w_rnd) < $signed(DMIN);

    always_ff @(posedge ap_clk) begin
        if (ce) begin
            r_a    <= din0;
            r_b    <= din1;
            r_p[0] <= w_prod;
            for (int i = 1; i < NP; i++) r_p[i] <= r_p[i-1];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_iv      <= 1'b0;
            r_pv      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            sat       <= 1'b0;
        end else if (ce) begin
            // the operand register takes the new term even under clear
            r_iv      <= in_valid;
            r_pv[0]   <= r_iv & ~acc_clr;
            for (int i = 1; i < NP; i++) r_pv[i] <= r_pv[i-1] & ~acc_clr;
            out_valid <= r_pv[NP-1] & w_last & ~acc_clr;
            if (acc_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_pv[NP-1]) begin
                r_acc <= w_last ? '0 : w_sum;
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                if (w_last) begin
                    dout <= w_hi ? DMAX[DOUT_WIDTH-1:0] : w_lo ? DMIN[DOUT_WIDTH-1:0] : w_rnd[DOUT_WIDTH-1:0];
                    sat  <= w_hi | w_lo;
                end
            end
        end
    end
endmodule

// File: tb/tb_cnn_mac_pipe_sat.sv
// tb_cnn_mac_pipe_sat: drives an ACC_LEN=1/SHIFT=0 and an ACC_LEN=4/SHIFT=8 instance
// with shared stimulus; expected windows are queued at accept time and checked on output.
module tb_cnn_mac_pipe_sat;
    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic               ce = 1'b0;
    logic               in_valid = 1'b0;
    logic               acc_clr = 1'b0;
    logic [13:0]        din0 = '0;
    logic [8:0]         din1 = '0;
    logic [1:0]         ov;
    logic [1:0][15:0]   dv;
    logic [1:0]         st;

    typedef struct {
        longint d;
        bit     s;
        int     due;
    } exp_t;

    exp_t   q [2][$];
    longint msum [2];
    int     mcnt [2];
    int     len [2];
    int     shf [2];
    bit     pov [2];
    longint pdv [2];
    bit     pst [2];
    int     total = 0;
    int     bad = 0;
    int     n = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_mac_pipe_sat #(.ACC_LEN(1), .SHIFT(0), .NUM_STAGE(3)) u1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_clr(acc_clr), .out_valid(ov[0]), .dout(dv[0]), .sat(st[0]));

    cnn_mac_pipe_sat #(.ACC_LEN(4), .SHIFT(8), .NUM_STAGE(3)) u4 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_clr(acc_clr), .out_valid(ov[1]), .dout(dv[1]), .sat(st[1]));

    task automatic check(string tag, longint got, longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got=%0d exp=%0d", tag, n, got, exp);
        end
    endtask

    task automatic model_add(int i, longint p);
        longint r;
        exp_t   e;
        msum[i] += p;
        mcnt[i]++;
        if (mcnt[i] == len[i]) begin
            r = msum[i];
            if (shf[i] > 0) r = (r + (64'sd1 <<< (shf[i] - 1))) >>> shf[i];
            e.s   = (r > 32767) || (r < -32768);
            e.d   = r > 32767 ? 32767 : r < -32768 ? -32768 : r;
            e.due = n + 3;
            q[i].push_back(e);
            mcnt[i] = 0;
            msum[i] = 0;
        end
    endtask

    task automatic step(bit c, bit v, longint a, longint b, bit clr = 1'b0, bit rst = 1'b0);
        exp_t e;
        string t;
        ce = c; in_valid = v; din0 = a[13:0]; din1 = b[8:0]; acc_clr = clr; ap_rst = rst;
        @(posedge ap_clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                q[i].delete(); mcnt[i] = 0; msum[i] = 0;
            end else if (c) begin
                if (i == 0) n++;
                if (clr) begin
                    q[i].delete(); mcnt[i] = 0; msum[i] = 0;
                end
                if (v) model_add(i, longint'($signed(din0)) * longint'($signed(din1)));
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            t = $sformatf("L%0d", len[i]);
            if (rst) begin
                check({t, "_rst_ov"}, ov[i], 0);
                check({t, "_rst_dout"}, $signed(dv[i]), 0);
                check({t, "_rst_sat"}, st[i], 0);
            end else if (c) begin
                if (q[i].size() > 0 && q[i][0].due == n) begin
                    e = q[i].pop_front();
                    check({t, "_ov"}, ov[i], 1);
                    check({t, "_dout"}, $signed(dv[i]), e.d);
                    check({t, "_sat"}, st[i], e.s);
                end else begin
                    check({t, "_ov_idle"}, ov[i], 0);
                end
            end else begin
                check({t, "_hold_ov"}, ov[i], pov[i]);
                check({t, "_hold_dout"}, $signed(dv[i]), pdv[i]);
                check({t, "_hold_sat"}, st[i], pst[i]);
            end
            pov[i] = ov[i];
            pdv[i] = $signed(dv[i]);
            pst[i] = st[i];
        end
    endtask

    task automatic idle(int k);
        for (int j = 0; j < k; j++) step(1, 0, 0, 0);
    endtask

    initial begin
        len = '{1, 4};
        shf = '{0, 8};
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        idle(2);
        // single-term windows: saturating and in-range
        step(1, 1, -8192, -256);
        step(1, 1, -100, 50);
        idle(5);
        step(1, 0, 0, 0, 1);
        // two back-to-back windows of (100,3)
        for (int j = 0; j < 8; j++) step(1, 1, 100, 3);
        idle(5);
        // negative half-way rounding, then just below half
        for (int j = 0; j < 4; j++) step(1, 1, -32, 3);
        for (int j = 0; j < 3; j++) step(1, 1, -32, 3);
        step(1, 1, -97, 1);
        idle(5);
        // stalls mid-window and while the result pulse is high
        step(1, 1, 1200, 40);
        step(1, 1, -700, 90);
        for (int j = 0; j < 5; j++) step(0, 1, 5, 5);
        step(1, 1, 333, -77);
        step(1, 1, 8191, 255);
        for (int j = 0; j < 10 && !ov[1]; j++) step(1, 0, 0, 0);
        check("stall_pulse_seen", ov[1], 1);
        for (int j = 0; j < 5; j++) step(0, 0, 0, 0);
        idle(5);
        // abort after two terms; clear cycle carries the first new term
        step(1, 1, 10, 5);
        step(1, 1, 20, 5);
        step(1, 1, 1000, 7, 1);
        step(1, 1, 2000, 9);
        step(1, 1, -500, 3);
        step(1, 1, 300, -200);
        idle(5);
        // reset mid-window while stalled
        step(1, 1, 4000, 100);
        step(1, 1, 4000, 100);
        step(0, 0, 0, 0, 0, 1);
        for (int j = 0; j < 4; j++) step(1, 1, -8192, 255);
        idle(5);
        for (int j = 0; j < 80; j++)
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 longint'($urandom_range(0, 16383)) - 8192, longint'($urandom_range(0, 511)) - 256,
                 $urandom_range(0, 29) == 0);
        idle(6);
        check("L1_drained", q[0].size(), 0);
        check("L4_drained", q[1].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
